// File: rtl/ddr_stream_pkg.sv
// Shared constants, widths and state encoding for the DDR read-stream path.
package ddr_stream_pkg;

  localparam int unsigned DEF_BEATS_PER_FRAME = 38400;
  localparam int unsigned DEF_ADDR_STEP       = 8;
  localparam int unsigned DEF_DEPTH           = 16;

  localparam int unsigned ADDR_W = 25;
  localparam int unsigned DATA_W = 128;
  localparam int unsigned FCW    = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    ISSUE = 2'd2
  } rd_state_t;

  // Beat addresses wrap modulo 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] addr_advance(input logic [ADDR_W-1:0] a,
                                                     input int unsigned       step);
    return a + ADDR_W'(step);
  endfunction

endpackage

// File: rtl/ddr_frame_reader_beat_fifo.sv
// Synchronous first-word-fall-through beat FIFO; the head is visible the cycle after a push.
module beat_fifo
  import ddr_stream_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   wr_en_i,
  input  logic [DATA_W-1:0]      wr_data_i,
  input  logic                   rd_en_i,
  output logic [DATA_W-1:0]      rd_data_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [CW-1:0]     count_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en_i) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_en_i) rd_ptr_q <= rd_ptr_q + AW'(1);
      unique case ({wr_en_i, rd_en_i})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_ptr_q] <= wr_data_i;
  end

  // Storage is never reset, so an empty FIFO presents zero rather than stale data.
  assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];
  assign count_o   = count_q;
  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == '0);

endmodule

// File: rtl/ddr_frame_reader.sv
// Frame read-request generator with credit-limited beat buffering toward the VGA pixel stream.
module ddr_frame_reader
  import ddr_stream_pkg::*;
#(
  parameter int unsigned BEATS_PER_FRAME = DEF_BEATS_PER_FRAME,
  parameter int unsigned ADDR_STEP       = DEF_ADDR_STEP,
  parameter int unsigned DEPTH           = DEF_DEPTH
) (
  input  logic              clk_133M,
  input  logic              rst_n_133M,
  input  logic              frame_start,
  input  logic [ADDR_W-1:0] base_address,
  input  logic              ram_busy,
  output logic              vga_read_req,
  output logic [ADDR_W-1:0] vga_read_address,
  input  logic              rd_data_valid,
  input  logic [DATA_W-1:0] vga_read_data,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              frame_busy,
  output logic              frame_done,
  output logic              rd_err
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  rd_state_t         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic              req_q, req_d;
  logic [FCW-1:0]    issued_cnt_q, issued_cnt_d;
  logic [FCW-1:0]    recv_cnt_q, recv_cnt_d;
  logic [FCW-1:0]    out_cnt_q, out_cnt_d;
  logic [CW-1:0]     outstanding_q, outstanding_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic [CW-1:0]     fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW:0]       inflight;
  logic              credit_ok;
  logic              issue;
  logic              ret_ok;
  logic              push;
  logic              pop;

  // Credits cover both beats in flight and beats already buffered, so the FIFO cannot overflow.
  assign inflight  = {1'b0, outstanding_q} + {1'b0, fifo_count};
  assign credit_ok = (inflight < (CW+1)'(DEPTH));
  assign issue     = (state_q == ISSUE) & ~ram_busy & credit_ok &
                     (issued_cnt_q != FCW'(BEATS_PER_FRAME));
  assign pop       = ~fifo_empty & pix_ready;
  assign ret_ok    = rd_data_valid & (outstanding_q != '0);
  assign push      = ret_ok & (~fifo_full | pop);

  always_comb begin
    state_d       = state_q;
    addr_d        = issue ? addr_advance(addr_q, ADDR_STEP) : addr_q;
    req_d         = issue;
    req_addr_d    = issue ? addr_q : req_addr_q;
    issued_cnt_d  = issued_cnt_q + FCW'(issue);
    recv_cnt_d    = recv_cnt_q + FCW'(ret_ok);
    out_cnt_d     = out_cnt_q + FCW'(pop);
    outstanding_d = outstanding_q + CW'(issue) - CW'(ret_ok);
    done_d        = 1'b0;
    err_d         = err_q | (rd_data_valid & (outstanding_q == '0)) |
                    (ret_ok & fifo_full & ~pop);

    unique case (state_q)
      IDLE: begin
        if (frame_start) begin
          state_d      = ISSUE;
          addr_d       = base_address;
          issued_cnt_d = '0;
          recv_cnt_d   = '0;
          out_cnt_d    = '0;
        end
      end
      ISSUE: begin
        if (issued_cnt_q == FCW'(BEATS_PER_FRAME)) state_d = DRAIN;
      end
      DRAIN: begin
        if (out_cnt_q == FCW'(BEATS_PER_FRAME)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_133M) begin
    if (!rst_n_133M) begin
      state_q       <= IDLE;
      req_q         <= 1'b0;
      req_addr_q    <= '0;
      issued_cnt_q  <= '0;
      recv_cnt_q    <= '0;
      out_cnt_q     <= '0;
      outstanding_q <= '0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      req_q         <= req_d;
      req_addr_q    <= req_addr_d;
      issued_cnt_q  <= issued_cnt_d;
      recv_cnt_q    <= recv_cnt_d;
      out_cnt_q     <= out_cnt_d;
      outstanding_q <= outstanding_d;
      done_q        <= done_d;
      err_q         <= err_d;
    end
  end

  // The running address is always reloaded on frame_start before use.
  always_ff @(posedge clk_133M) begin
    addr_q <= addr_d;
  end

  beat_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_i    (clk_133M),
    .rst_n_i  (rst_n_133M),
    .wr_en_i  (push),
    .wr_data_i(vga_read_data),
    .rd_en_i  (pop),
    .rd_data_o(pix_data),
    .count_o  (fifo_count),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty)
  );

  assign vga_read_req     = req_q;
  assign vga_read_address = req_addr_q;
  assign pix_valid        = ~fifo_empty;
  assign frame_busy       = (state_q != IDLE);
  assign frame_done       = done_q;
  assign rd_err           = err_q;

endmodule

// File: tb/tb_ddr_frame_reader.sv
// Scoreboard bench for ddr_frame_reader with a fixed-latency arbiter model.
module tb_ddr_frame_reader;
  import ddr_stream_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              frame_start;
  logic [ADDR_W-1:0] base_address;
  logic              ram_busy;
  logic              vga_read_req;
  logic [ADDR_W-1:0] vga_read_address;
  logic              rd_data_valid;
  logic [DATA_W-1:0] vga_read_data;
  logic [DATA_W-1:0] pix_data;
  logic              pix_valid;
  logic              pix_ready;
  logic              frame_busy;
  logic              frame_done;
  logic              rd_err;

  ddr_frame_reader dut (
    .clk_133M        (clk),
    .rst_n_133M      (rst_n),
    .frame_start     (frame_start),
    .base_address    (base_address),
    .ram_busy        (ram_busy),
    .vga_read_req    (vga_read_req),
    .vga_read_address(vga_read_address),
    .rd_data_valid   (rd_data_valid),
    .vga_read_data   (vga_read_data),
    .pix_data        (pix_data),
    .pix_valid       (pix_valid),
    .pix_ready       (pix_ready),
    .frame_busy      (frame_busy),
    .frame_done      (frame_done),
    .rd_err          (rd_err)
  );

  always #4 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int              due;
    logic [ADDR_W-1:0] addr;
  } ret_t;

  ret_t              pend[$];
  logic [DATA_W-1:0] exp_q[$];
  int                errors = 0;
  int                checks = 0;
  int                req_cnt = 0;
  int                pop_cnt = 0;
  int                done_cnt = 0;
  logic [ADDR_W-1:0] exp_addr = '0;
  logic [ADDR_W-1:0] last_addr = '0;
  logic [ADDR_W-1:0] first_addrs[2];
  logic              busy_prev = 1'b1;
  logic              inject = 1'b0;

  function automatic logic [DATA_W-1:0] beat_of(input logic [ADDR_W-1:0] a);
    return {3'b101, a, ~a, a ^ 25'h1555555, ~a ^ 25'h0AAAAAA, a};
  endfunction

  task automatic check(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Request monitor: address contiguity, busy compliance, feeds the arbiter model.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && vga_read_req) begin
        check("req_addr", vga_read_address, exp_addr);
        check("req_after_busy_low", busy_prev, 1'b0);
        if (req_cnt < 2) first_addrs[req_cnt] = vga_read_address;
        pend.push_back('{cyc + 5, vga_read_address});
        last_addr = vga_read_address;
        exp_addr  = exp_addr + 25'd8;
        req_cnt++;
      end
      busy_prev = ram_busy;
    end
  end

  // Arbiter model: each beat comes back five cycles after its request.
  initial begin
    rd_data_valid = 1'b0;
    vga_read_data = '0;
    forever begin
      @(posedge clk);
      #1;
      rd_data_valid = inject;
      vga_read_data = '0;
      if (!rst_n) begin
        pend.delete();
      end else if (pend.size() > 0 && pend[0].due <= cyc) begin
        ret_t r;
        r = pend.pop_front();
        rd_data_valid = 1'b1;
        vga_read_data = beat_of(r.addr);
        exp_q.push_back(beat_of(r.addr));
      end
    end
  end

  // Output monitor: pops the scoreboard on every accepted beat.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
      end else begin
        if (pix_valid && pix_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL pix_unexpected: got %h expected no beat", pix_data);
          end else begin
            check("pix_data", pix_data, exp_q.pop_front());
          end
          pop_cnt++;
        end
        if (frame_done) begin
          done_cnt++;
          check("busy_low_at_done", frame_busy, 1'b0);
        end
      end
    end
  end

  task automatic check_reset(input string tag);
    check({tag, "_req"}, vga_read_req, 1'b0);
    check({tag, "_addr"}, vga_read_address, '0);
    check({tag, "_pix_valid"}, pix_valid, 1'b0);
    check({tag, "_pix_data"}, pix_data, '0);
    check({tag, "_frame_busy"}, frame_busy, 1'b0);
    check({tag, "_frame_done"}, frame_done, 1'b0);
    check({tag, "_rd_err"}, rd_err, 1'b0);
  endtask

  task automatic do_reset(input string tag);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_reset(tag);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic start_frame(input logic [ADDR_W-1:0] b);
    @(posedge clk);
    #1;
    frame_start  = 1'b1;
    base_address = b;
    exp_addr     = b;
    req_cnt      = 0;
    @(posedge clk);
    #1 frame_start = 1'b0;
    @(negedge clk);
    check("latency_no_req_1", vga_read_req, 1'b0);
    check("frame_busy_rise", frame_busy, 1'b1);
    @(negedge clk);
    check("latency_req_2", vga_read_req, 1'b1);
    check("first_addr", vga_read_address, b);
  endtask

  initial begin
    int n;
    rst_n        = 1'b0;
    frame_start  = 1'b0;
    base_address = '0;
    ram_busy     = 1'b0;
    pix_ready    = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("por");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Frame 1: downstream stalled, credits must cap requests at DEPTH.
    pix_ready = 1'b0;
    pop_cnt   = 0;
    start_frame(25'h0200000);
    for (int i = 0; i < 6; i++) begin
      repeat (10) @(negedge clk);
      check("stall_pix_valid", pix_valid, 1'b1);
      check("stall_pix_hold", pix_data, beat_of(25'h0200000));
    end
    check("stall_req_count", req_cnt, 16);

    // A second frame_start mid-frame must not reload the address.
    @(posedge clk);
    #1 frame_start = 1'b1;
    base_address = 25'h0AAAAA0;
    @(posedge clk);
    #1 frame_start = 1'b0;

    @(posedge clk);
    #1 pix_ready = 1'b1;
    repeat (20) @(negedge clk);
    check("resume_after_ready", req_cnt > 16, 1'b1);

    n = req_cnt;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1 ram_busy = ~ram_busy;
    end
    @(posedge clk);
    #1 ram_busy = 1'b0;
    check("toggle_made_progress", (req_cnt - n) >= 15, 1'b1);

    for (int i = 0; i < 3000 && pop_cnt < 100; i++) @(negedge clk);
    check("reach_100_beats", pop_cnt >= 100, 1'b1);
    do_reset("midframe_rst");

    // Frame 2: full clean frame after reset.
    pop_cnt  = 0;
    done_cnt = 0;
    start_frame(25'h0000100);
    for (int i = 0; i < 45000 && done_cnt == 0; i++) @(negedge clk);
    check("frame2_done_seen", done_cnt >= 1, 1'b1);
    check("frame2_req_count", req_cnt, 38400);
    check("frame2_second_addr", first_addrs[1], 25'h0000108);
    check("frame2_last_addr", last_addr, 25'h004B0F8);
    check("frame2_pop_count", pop_cnt, 38400);
    repeat (5) @(negedge clk);
    check("frame2_done_once", done_cnt, 1);
    check("frame2_rd_err", rd_err, 1'b0);
    check("frame2_busy_low", frame_busy, 1'b0);
    check("frame2_fifo_empty", pix_valid, 1'b0);

    // Frame 3: restart from new base, address wraps at 2^25.
    start_frame(25'h1FFFFF8);
    repeat (10) @(negedge clk);
    check("frame3_wrap_addr", first_addrs[1], 25'h0000000);
    do_reset("frame3_rst");

    // Stray beat in IDLE: dropped, sticky error until reset.
    repeat (3) @(negedge clk);
    inject = 1'b1;
    @(negedge clk);
    inject = 1'b0;
    @(negedge clk);
    check("stray_rd_err_set", rd_err, 1'b1);
    check("stray_fifo_empty", pix_valid, 1'b0);
    repeat (10) @(negedge clk);
    check("stray_rd_err_sticky", rd_err, 1'b1);
    check("stray_fifo_still_empty", pix_valid, 1'b0);
    do_reset("err_clear_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ddr_frame_reader.md
# ddr_frame_reader

Read-side request generator and beat buffer between the VGA output path and the DDR request arbiter, in the `clk_133M` domain. On `frame_start` it issues one read request per 128-bit beat for a full frame, respecting the arbiter's `busy`. It buffers returned beats in a credit-limited local FIFO and presents them on a valid/ready stream to the downstream clock-crossing FIFO.

## Interface
- `BEATS_PER_FRAME`, 38400: 640×480 pixels, 16-bit, 8 pixels per beat.
- `ADDR_STEP`, 8: address increment per beat (16-bit word addressing).
- `DEPTH`, 16: local beat FIFO depth, power of two; also the credit limit.
- `clk_133M` in 1: sole clock.
- `rst_n_133M` in 1: synchronous, active-low reset.
- `frame_start` in 1: single-cycle pulse; begins a frame read.
- `base_address` in 25: frame base; sampled on an accepted `frame_start`.
- `ram_busy` in 1: arbiter busy; no request may be issued while high.
- `vga_read_req` out 1: single-cycle read request pulse.
- `vga_read_address` out 25: address, valid with `vga_read_req`.
- `rd_data_valid` in 1: returned beat strobe.
- `vga_read_data` in 128: returned beat.
- `pix_data` out 128: output beat.
- `pix_valid` out 1: output beat valid.
- `pix_ready` in 1: downstream accept.
- `frame_busy` out 1: high from an accepted `frame_start` until `frame_done`.
- `frame_done` out 1: single-cycle pulse after the last beat is consumed.
- `rd_err` out 1: sticky; set by a beat returned with zero outstanding or by a FIFO overflow. Cleared only by reset.

## Operation
- FSM states: IDLE, ISSUE, DRAIN.
- IDLE: `frame_start` latches `base_address` into the address register, clears `issued_cnt`, `recv_cnt` and `out_cnt`, and goes to ISSUE. `frame_start` outside IDLE is ignored.
- ISSUE:
  - A request is issued when `~ram_busy` and `outstanding + fifo_count < DEPTH`.
  - On issue, `vga_read_req` is pulsed, `outstanding` and `issued_cnt` are incremented, and the address advances by `ADDR_STEP`, wrapping modulo 2^25.
  - When `issued_cnt == BEATS_PER_FRAME`, the FSM goes to DRAIN.
- `outstanding` changes as follows:
  - `rd_data_valid` decrements it and pushes the beat into the FIFO.
  - A simultaneous issue and return leaves it unchanged.
  - `rd_data_valid` with `outstanding == 0`: the beat is dropped, `rd_err` is set, and the counter is not decremented.
- Output:
  - FIFO head drives `pix_data`/`pix_valid`.
  - A pop occurs on `pix_valid & pix_ready`; each pop increments `out_cnt`.
  - Simultaneous push and pop on a full FIFO is legal.
  - A push to a full FIFO without a pop sets `rd_err` and drops the beat. The credit rule makes this unreachable with a conforming arbiter.
- DRAIN: when `out_cnt == BEATS_PER_FRAME`, `frame_done` pulses and the FSM returns to IDLE. `frame_busy` falls in the same cycle.
- Reset mid-frame: FSM goes to IDLE and all counters and the FIFO are cleared. The arbiter shares the reset, so no stale beats are expected.

## Timing
- Reset values:
  - `vga_read_req`, `pix_valid`, `frame_busy`, `frame_done`, `rd_err` = 0.
  - `vga_read_address` = 0; `pix_data` = 0.
- First `vga_read_req` occurs 2 cycles after the `frame_start` cycle if `ram_busy` is low.
- Requests are registered. The decision uses `ram_busy` and the counters of the current cycle; the pulse appears the next cycle. Maximum rate is one request per cycle.
- `ram_busy` sampled high suppresses the request for that cycle; there is no queuing inside this block.
- Return to output: a beat pushed in cycle N is visible on `pix_valid`/`pix_data` in cycle N+1 if the FIFO was empty (registered FWFT).
- `pix_data` holds stable while `pix_valid & ~pix_ready`.
- Counter widths: 16 bits for the frame counters, $clog2(DEPTH)+1 bits for `outstanding` and `fifo_count`.

## Structure
- Package `ddr_stream_pkg`:
  - Default constants: `BEATS_PER_FRAME`, `ADDR_STEP`, `DEPTH`.
  - FSM state enum `rd_state_t` (IDLE/DRAIN/ISSUE).
  - Address width 25 and data width 128.
- Sub-module `beat_fifo`: synchronous FWFT FIFO, 128 × `DEPTH`, with count, full and empty outputs. Credit, FSM and error logic stay in the top.

## Test plan
- Base 0x0000100, `ram_busy`=0, `pix_ready`=1, arbiter returns each beat 5 cycles after its request.
  - First address is 0x0000100, the 2nd is 0x0000108, the last is 0x0000100 + 38399·8.
  - Exactly 38400 requests are issued, `frame_done` pulses once, and `rd_err` stays 0.
- `pix_ready`=0 throughout:
  - Exactly 16 requests are issued, then issuing halts.
  - `pix_valid` stays 1 and `pix_data` holds the first beat.
  - After `pix_ready` rises, issuing resumes.
- `ram_busy` toggles every cycle: requests appear only in cycles following a low sample, and the address sequence is contiguous with no gaps or repeats.
- A second `frame_start` while `frame_busy`=1 is ignored (no address reload, no counter reset). A `frame_start` after `frame_done` restarts from the new base.
- `rd_data_valid` pulsed in IDLE sets `rd_err`=1, the FIFO stays empty, and `rd_err` persists until reset.
- Reset asserted after 100 beats: all outputs return to their reset values next cycle, and a subsequent `frame_start` produces a full clean frame.
